// File: rtl/wb_defs.sv
// Shared write-back definitions: result-source codes (also used by the datapath
// write-data mux), sequencer state encodings and the default watchdog limit.
package wb_defs;

    localparam logic [2:0] SRC_ULA   = 3'b000;
    localparam logic [2:0] SRC_LS    = 3'b001;
    localparam logic [2:0] SRC_HI    = 3'b010;
    localparam logic [2:0] SRC_LO    = 3'b011;
    localparam logic [2:0] SRC_SHIFT = 3'b100;
    localparam logic [2:0] SRC_LT32  = 3'b101;

    localparam int unsigned WB_TIMEOUT_DEFAULT = 15;
    localparam int unsigned WB_CNT_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_WRITE = 2'b10,
        ST_ERR   = 2'b11
    } wb_state_e;

    function automatic logic src_is_legal(input logic [2:0] src);
        return (src <= SRC_LT32);
    endfunction

    // ULA and LT32 results are combinational in the datapath, so always ready.
    function automatic logic src_is_ready(input logic [2:0] src,
                                          input logic       ls_valid,
                                          input logic       md_busy,
                                          input logic       shift_done);
        logic rdy;
        rdy = 1'b0;
        case (src)
            SRC_ULA, SRC_LT32: rdy = 1'b1;
            SRC_LS:            rdy = ls_valid;
            SRC_HI, SRC_LO:    rdy = !md_busy;
            SRC_SHIFT:         rdy = shift_done;
            default:           rdy = 1'b0;
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/writeback_ctrl.sv
// Write-back sequencer: accepts one request, waits for its result source, then
// issues a single register-file write (or an abort pulse on illegal/timeout).
module writeback_ctrl
    import wb_defs::*;
#(
    parameter int unsigned TIMEOUT = WB_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [2:0] wb_src,
    input  logic [4:0] wb_rd,
    output logic       wb_ready,
    input  logic       ls_valid,
    input  logic       md_busy,
    input  logic       shift_done,
    output logic [2:0] write_data_sel,
    output logic [4:0] reg_dst,
    output logic       reg_write,
    output logic       wb_done,
    output logic       wb_err,
    output logic [1:0] dbg_state
);

    localparam logic [WB_CNT_W-1:0] TIMEOUT_C = WB_CNT_W'(TIMEOUT);
    localparam logic [WB_CNT_W-1:0] CNT_MAX   = '1;

    wb_state_e           state, state_nxt;
    logic [WB_CNT_W-1:0] cnt, cnt_nxt;
    logic                accept;
    logic                src_rdy;

    // Handshake: a request transfers on the rising edge where wb_req && wb_ready;
    // the requester holds wb_req and its payload stable until that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            write_data_sel <= SRC_ULA;
            reg_dst        <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                write_data_sel <= wb_src;
                reg_dst        <= wb_rd;
            end
        end
    end

    assign src_rdy   = src_is_ready(write_data_sel, ls_valid, md_busy, shift_done);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        wb_ready  = 1'b0;
        reg_write = 1'b0;
        wb_done   = 1'b0;
        wb_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                wb_ready = 1'b1;
                if (wb_req) begin
                    accept    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = src_is_legal(wb_src) ? ST_WAIT : ST_ERR;
                end
            end
            ST_WAIT: begin
                // A source becoming ready on the limit cycle still wins.
                if (src_rdy) begin
                    state_nxt = ST_WRITE;
                end else if (cnt >= TIMEOUT_C) begin
                    state_nxt = ST_ERR;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_WRITE: begin
                reg_write = (reg_dst != 5'd0);
                wb_done   = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                wb_err    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
